// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front end.
// Issues word-aligned sequential fetches to a multi-cycle instruction memory
// (one request in flight at a time) and buffers the returned words in a
// DEPTH-entry FIFO whose head feeds IF/ID through a valid/ready handshake.
// A redirect flushes the queue and drops any response still in flight.
// Optional feature: define INST_FETCH_QUEUE_BYPASS_EN to present a response
// to IF/ID in the same cycle it arrives while the queue is empty.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_plus_4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_plus_4;
    logic [31:0]    slot_inst [DEPTH];
    logic [31:0]    slot_pc4  [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after_pop;
    logic           resp_here;
    logic           bypass;
    logic           push;
    logic           pop;

    assign fetch_pc_plus_4 = fetch_pc + 32'd4;

    // A response that belongs to a live (not discarded) fetch.
    assign resp_here = (state == S_WAIT) && imem_rvalid;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && resp_here && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign imem_req      = (state == S_REQ);
    assign imem_addr     = fetch_pc;
    assign out_valid     = ((count != '0) || bypass) && !redirect;
    assign out_inst      = bypass ? imem_rdata      : slot_inst[rd_ptr];
    assign out_pc_plus_4 = bypass ? fetch_pc_plus_4 : slot_pc4[rd_ptr];

    // A bypassed word consumed by IF/ID never enters the queue.
    assign pop             = out_valid && out_ready && !bypass;
    assign push            = resp_here && !redirect && !(bypass && out_ready);
    assign count_after_pop = count - CW'(pop);

    // Fetch sequencer next state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        if (redirect) begin
            case (state)
                // A response arriving with the redirect is simply dropped here;
                // waiting in DISCARD for a second response would never end.
                S_WAIT:    state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
                S_REQ:     state_nxt = imem_ready  ? S_DISCARD : S_IDLE;
                S_DISCARD: state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
                default:   state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE:    if (count_after_pop < CW'(DEPTH)) state_nxt = S_REQ;
                S_REQ:     if (imem_ready)  state_nxt = S_WAIT;
                S_WAIT:    if (imem_rvalid) state_nxt = S_IDLE;
                S_DISCARD: if (imem_rvalid) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch address: restarts on redirect, advances on each live response.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (resp_here) begin
            fetch_pc <= fetch_pc_plus_4;
        end
    end

    // Instruction queue storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: slots are reset because the head slot is visible on out_* straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                slot_inst[i] <= '0;
                slot_pc4[i]  <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slot_inst[wr_ptr] <= imem_rdata;
                slot_pc4[wr_ptr]  <= fetch_pc_plus_4;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: self-checking bench for inst_fetch_queue.
// A queue-based reference model predicts the outputs every cycle; directed
// phases pin fetch order, full/empty behaviour, redirect handling and
// address wrap with literal expectations, then a long random phase runs.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus_4;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc_plus_4(out_pc_plus_4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    // Reference model: queued words, next fetch address, request/in-flight flags.
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_req;
    bit          m_busy;
    bit          m_drop;
    int          mem_cnt;

    // Stimulus knobs.
    int          ready_pct  = 100;
    int          oready_pct = 100;
    int          redir_pct  = 0;
    int          stray_pct  = 0;
    int          reset_pct  = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    bit          f_redir    = 0;
    bit          f_oready   = 0;
    bit          f_reset    = 0;
    logic [31:0] f_rpc      = '0;

    // Observation logs.
    logic [31:0] acc_log[$];
    ent_t        out_log[$];
    logic [31:0] word_log[$];
    bit          last_valid;
    bit          first_rv_seen = 0;
    logic        first_rv_valid;
    logic [31:0] first_rv_inst;
    logic [31:0] first_rv_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
        word_log.delete();
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_req  = 0;
        m_busy = 0;
        m_drop = 0;
    endtask

    // Outputs the model requires for the current cycle's inputs.
    task automatic model_view(output bit byp, output bit ev, output ent_t head);
        byp = 0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && imem_rvalid && m_busy && !m_drop && !redirect;
`endif
        ev        = ((mq.size() != 0) || byp) && !redirect;
        head.inst = '0;
        head.pc4  = '0;
        if (byp) begin
            head.inst = imem_rdata;
            head.pc4  = m_pc + 32'd4;
        end else if (mq.size() != 0) begin
            head = mq[0];
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_update(input bit byp, input bit ev);
        bit   pop;
        bit   idle;
        bit   accepted;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        pop      = ev && out_ready;
        idle     = !m_req && !m_busy;
        accepted = m_req && imem_ready;
        if (redirect) begin
            m_busy = (m_busy && !imem_rvalid) || accepted;
            m_drop = m_busy;
            if (accepted) mem_cnt = $urandom_range(lat_min, lat_max);
            mq.delete();
            m_req = 0;
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop && !byp) void'(mq.pop_front());
            if (m_busy && imem_rvalid) begin
                if (!m_drop) begin
                    if (!(byp && pop)) begin
                        e.inst = imem_rdata;
                        e.pc4  = m_pc + 32'd4;
                        mq.push_back(e);
                    end
                    m_pc = m_pc + 32'd4;
                end
                m_busy = 0;
                m_drop = 0;
            end else if (accepted) begin
                m_req   = 0;
                m_busy  = 1;
                m_drop  = 0;
                mem_cnt = $urandom_range(lat_min, lat_max);
            end else if (idle) begin
                m_req = (mq.size() < DEPTH);
            end
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge, update model at posedge.
    task automatic step();
        bit   byp;
        bit   ev;
        ent_t hd;
        ent_t e;
        reset      = f_reset || pct(reset_pct);
        imem_ready = pct(ready_pct);
        imem_rdata = $urandom;
        imem_rvalid = 1'b0;
        if (m_busy) begin
            if (mem_cnt == 0) imem_rvalid = 1'b1;
            else mem_cnt--;
        end else if (pct(stray_pct)) begin
            imem_rvalid = 1'b1;
        end
        redirect = f_redir || pct(redir_pct);
        if (f_redir) redirect_pc = f_rpc;
        else if (pct(20)) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else redirect_pc = $urandom & 32'h0000_03FF;
        out_ready = f_oready || pct(oready_pct);
        f_redir  = 0;
        f_oready = 0;
        f_reset  = 0;

        @(negedge clock);
        model_view(byp, ev, hd);
        check("imem_req", imem_req, m_req);
        if (m_req) check("imem_addr", imem_addr, m_pc);
        check("out_valid", out_valid, ev);
        if (ev) begin
            check("out_inst", out_inst, hd.inst);
            check("out_pc_plus_4", out_pc_plus_4, hd.pc4);
        end
        if (!reset) begin
            if (imem_req && imem_ready) acc_log.push_back(imem_addr);
            if (out_valid && out_ready) begin
                e.inst = out_inst;
                e.pc4  = out_pc_plus_4;
                out_log.push_back(e);
            end
            if (imem_rvalid && m_busy && !m_drop && !redirect) begin
                word_log.push_back(imem_rdata);
                if (!first_rv_seen) begin
                    first_rv_seen  = 1;
                    first_rv_valid = out_valid;
                    first_rv_inst  = out_inst;
                    first_rv_data  = imem_rdata;
                end
            end
        end
        last_valid = out_valid;

        @(posedge clock);
        model_update(byp, ev);
        #1;
    endtask

    task automatic do_reset();
        f_reset = 1;
        step();
        clear_logs();
    endtask

    initial begin
        bit found;
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc_plus_4", out_pc_plus_4, 0);
        @(posedge clock);
        #1;

        // Sequential fetch, 2-cycle response latency, IF/ID always ready.
        clear_logs();
        repeat (16) step();
        check("seq_accepts", acc_log.size() >= 3, 1);
        check("seq_outputs", out_log.size() >= 3, 1);
        if (acc_log.size() >= 3 && out_log.size() >= 3 && word_log.size() >= 3) begin
            check("seq_addr0", acc_log[0], 32'h0);
            check("seq_addr1", acc_log[1], 32'h4);
            check("seq_addr2", acc_log[2], 32'h8);
            check("seq_pc4_0", out_log[0].pc4, 32'h4);
            check("seq_pc4_1", out_log[1].pc4, 32'h8);
            check("seq_pc4_2", out_log[2].pc4, 32'hC);
            for (int i = 0; i < 3; i++) check("seq_inst", out_log[i].inst, word_log[i]);
        end
        check("first_resp_seen", first_rv_seen, 1);
        if (first_rv_seen) begin
`ifdef INST_FETCH_QUEUE_BYPASS_EN
            check("bypass_valid", first_rv_valid, 1);
            check("bypass_inst", first_rv_inst, first_rv_data);
`else
            check("no_bypass_valid", first_rv_valid, 0);
`endif
        end

        // Full queue: IF/ID stalled, exactly DEPTH fetches, then one pop.
        do_reset();
        oready_pct = 0;
        lat_min    = 0;
        lat_max    = 0;
        repeat (30) step();
        check("full_accepts", acc_log.size(), 4);
        check("full_req_low", imem_req, 0);
        f_oready = 1;
        step();
        check("full_pop_req", imem_req, 1);
        check("full_pop_addr", imem_addr, 32'h10);

        // Redirect while waiting for a response.
        oready_pct = 100;
        lat_min    = 2;
        lat_max    = 2;
        do_reset();
        step();
        step();
        f_redir = 1;
        f_rpc   = 32'h0000_0103;
        step();
        clear_logs();
        repeat (16) step();
        check("redir_has_fetch", (acc_log.size() >= 1) && (out_log.size() >= 1), 1);
        if (acc_log.size() >= 1 && out_log.size() >= 1 && word_log.size() >= 1) begin
            check("redir_addr", acc_log[0], 32'h100);
            check("redir_pc4", out_log[0].pc4, 32'h104);
            check("redir_inst", out_log[0].inst, word_log[0]);
        end

        // Redirect coinciding with a response and a pop.
        do_reset();
        oready_pct = 0;
        lat_min    = 0;
        lat_max    = 0;
        found      = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() >= 1 && m_busy && mem_cnt == 0) begin
                f_redir  = 1;
                f_rpc    = 32'h0000_0200;
                f_oready = 1;
                found    = 1;
            end
            step();
        end
        check("collide_reached", found, 1);
        step();
        check("collide_empty", last_valid, 0);
        oready_pct = 100;
        clear_logs();
        repeat (12) step();
        check("collide_next", out_log.size() >= 1, 1);
        if (out_log.size() >= 1) check("collide_pc4", out_log[0].pc4, 32'h204);

        // Address wrap at the top of the address space.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        f_redir = 1;
        f_rpc   = 32'hFFFF_FFFE;
        step();
        repeat (16) step();
        check("wrap_fetches", (acc_log.size() >= 2) && (out_log.size() >= 2), 1);
        if (acc_log.size() >= 2 && out_log.size() >= 2) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc_log[1], 32'h0);
            check("wrap_pc4_0", out_log[0].pc4, 32'h0);
            check("wrap_pc4_1", out_log[1].pc4, 32'h4);
        end

        // Random traffic against the model.
        do_reset();
        ready_pct  = 60;
        oready_pct = 50;
        redir_pct  = 5;
        stray_pct  = 2;
        reset_pct  = 1;
        lat_min    = 0;
        lat_max    = 3;
        repeat (4000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
